stopwatch_display: RTL and testbench



---
 rtl/stopwatch_display_pkg.sv | 57 +++++
 rtl/stopwatch_display_if.sv | 12 +
 rtl/stopwatch_display_bin2bcd_seq.sv | 52 +++++
 rtl/stopwatch_display.sv | 118 +++++++++++
 tb/tb_stopwatch_display.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch display: FSM states, 7-segment codes, digit slots.
// No logic with latency; seg_encode is purely combinational.
// No flow control; constants only.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Display-register digit codes beyond 0-9
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam logic [7:0] MIN_MAX = 8'd99;
  localparam logic [7:0] SEC_MAX = 8'd59;

  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:      s = SEG_0;
      4'd1:      s = SEG_1;
      4'd2:      s = SEG_2;
      4'd3:      s = SEG_3;
      4'd4:      s = SEG_4;
      4'd5:      s = SEG_5;
      4'd6:      s = SEG_6;
      4'd7:      s = SEG_7;
      4'd8:      s = SEG_8;
      4'd9:      s = SEG_9;
      CODE_DASH: s = SEG_DASH;
      default:   s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Counter-chain to display link: sampled minutes/seconds with a load strobe and busy status.
// Wires only, no latency.
// Producer must not expect a load to be queued while busy is high; such loads are dropped.
interface stopwatch_display_if;
  logic       load;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       busy;

  modport master (output load, output minutes, output seconds, input busy);
  modport slave  (input load, input minutes, input seconds, output busy);
endinterface

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to two BCD nibbles (tens/ones), one bit per clock.
// Latency: 8 clocks after start_i; done_o is high during the cycle whose edge completes the 8th shift.
// No backpressure: start_i restarts the engine unconditionally.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [7:0] sh_q, sh_d;
  logic [7:0] bcd_q, bcd_d;
  logic [7:0] bcd_adj;
  logic [2:0] cnt_q;
  logic       run_q;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    // Hundreds carry is dropped; out-of-range values are blanked by the caller.
    bcd_d = {bcd_adj[6:0], sh_q[7]};
    sh_d  = {sh_q[6:0], 1'b0};
  end

  assign done_o = run_q && (cnt_q == 3'd7);
  assign tens_o = bcd_q[7:4];
  assign ones_o = bcd_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS stopwatch display: BCD-converts minutes/seconds on load and scans 4 common-anode digits.
// Latency: display register updates 9 edges after load; an/seg/dp lag digit_idx by one cycle.
// load is accepted only while idle; loads during busy are dropped, not queued.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_display_if.slave  cnt,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  state_e           state_q;
  logic             busy_q;
  logic [7:0]       min_q, sec_q;
  logic [3:0][3:0]  disp_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [1:0]       digit_idx_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic       start;
  logic       min_done, sec_done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  assign start    = (state_q == IDLE) && cnt.load;
  assign cnt.busy = busy_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

  bin2bcd_seq u_min_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .bin_i  (cnt.minutes),
    .done_o (min_done),
    .tens_o (min_tens),
    .ones_o (min_ones)
  );

  bin2bcd_seq u_sec_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .bin_i  (cnt.seconds),
    .done_o (sec_done),
    .tens_o (sec_tens),
    .ones_o (sec_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      min_q   <= '0;
      sec_q   <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt.load) begin
            min_q   <= cnt.minutes;
            sec_q   <= cnt.seconds;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          if (min_done && sec_done) state_q <= LATCH;
        end
        LATCH: begin
          // Each field is range-checked on its own raw value
          disp_q[DIG_MIN_TENS] <= (min_q > MIN_MAX) ? CODE_DASH : min_tens;
          disp_q[DIG_MIN_ONES] <= (min_q > MIN_MAX) ? CODE_DASH : min_ones;
          disp_q[DIG_SEC_TENS] <= (sec_q > SEC_MAX) ? CODE_DASH : sec_tens;
          disp_q[DIG_SEC_ONES] <= (sec_q > SEC_MAX) ? CODE_DASH : sec_ones;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Scan runs free of the FSM, so a display update shows on the current digit at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= DIG_SEC_ONES;
      an_q        <= 4'hF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q  <= '0;
        digit_idx_q <= digit_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << digit_idx_q);
      seg_q <= seg_encode(disp_q[digit_idx_q]);
      dp_q  <= (digit_idx_q != DIG_MIN_ONES);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: vector table plus hand-written corner sequences.
module tb_stopwatch_display;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SD = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  stopwatch_display_if sw_if ();

  stopwatch_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (sw_if.slave),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected digits {d3,d2,d1,d0}, 7 bits each
  logic [27:0] exp_q[$];

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  s;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    sw_if.minutes = m;
    sw_if.seconds = s;
    sw_if.load    = 1'b1;
    @(negedge clk);
    sw_if.load    = 1'b0;
  endtask

  task automatic wait_busy(input int exp_n, input string name);
    int n = 0;
    while (sw_if.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp_n);
  endtask

  task automatic check_display(input string name);
    logic [27:0] e;
    bit          seen[4];
    int          idx;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    checks--;
    e = exp_q.pop_front();
    @(negedge clk);
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL %s_an_onehot: got %b expected one low bit", name, an);
      end else if (!seen[idx]) begin
        seen[idx] = 1'b1;
        check($sformatf("%s_seg%0d", name, idx), 32'(seg), 32'(e[idx*7 +: 7]));
        check($sformatf("%s_dp%0d", name, idx), 32'(dp), 32'(idx != 2));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s_seen%0d", name, i), 32'(seen[i]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    sw_if.load    = 1'b0;
    sw_if.minutes = '0;
    sw_if.seconds = '0;

    vecs[0] = '{8'd42,  8'd17, {S4, S2, S1, S7}};
    vecs[1] = '{8'd99,  8'd59, {S9, S9, S5, S9}};
    vecs[2] = '{8'd0,   8'd0,  {S0, S0, S0, S0}};
    vecs[3] = '{8'd150, 8'd75, {SD, SD, SD, SD}};
    vecs[4] = '{8'd100, 8'd30, {SD, SD, S3, S0}};
    vecs[5] = '{8'd5,   8'd7,  {S0, S5, S0, S7}};
    vecs[6] = '{8'd99,  8'd60, {S9, S9, SD, SD}};

    // Reset state
    #22;
    check("rst_busy", 32'(sw_if.busy), 32'd0);
    check("rst_an",   32'(an),  32'hF);
    check("rst_seg",  32'(seg), 32'h7F);
    check("rst_dp",   32'(dp),  32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_%0d", k), 32'(an), 32'(4'(~(4'b0001 << (k / SCAN_DIV)))));
      check($sformatf("scan_seg_%0d", k), 32'(seg), 32'(S0));
      check($sformatf("scan_dp_%0d", k), 32'(dp), 32'((k / SCAN_DIV) != 2));
    end

    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].m, vecs[v].s);
      exp_q.push_back(vecs[v].segs);
      wait_busy(9, $sformatf("vec%0d_busy", v));
      check_display($sformatf("vec%0d", v));
    end

    // Load 3 cycles into a conversion is dropped
    do_load(8'd12, 8'd34);
    exp_q.push_back({S1, S2, S3, S4});
    @(negedge clk);
    @(negedge clk);
    do_load(8'd56, 8'd7);
    wait_busy(6, "ign_busy");
    check_display("ign");

    // Load on the first cycle busy is low is accepted
    do_load(8'd1, 8'd2);
    wait_busy(9, "b2b_first_busy");
    do_load(8'd42, 8'd17);
    exp_q.push_back({S4, S2, S1, S7});
    wait_busy(9, "b2b_second_busy");
    check_display("b2b");

    // Reset in the middle of a conversion
    do_load(8'd99, 8'd59);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(sw_if.busy), 32'd0);
    check("abort_an",   32'(an),  32'hF);
    check("abort_seg",  32'(seg), 32'h7F);
    check("abort_dp",   32'(dp),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({S0, S0, S0, S0});
    check_display("abort_zero");
    do_load(8'd42, 8'd17);
    exp_q.push_back({S4, S2, S1, S7});
    wait_busy(9, "after_abort_busy");
    check_display("after_abort");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
